router_reg_gen: RTL

- Parametrised packet datapath register for the router input stage. Next generation of the router's byte register.
- Has its own packet sequencer: header decode, payload forwarding, parity byte capture and check.
- Adds a selectable checksum mode, a payload length check, destination-address validation with packet drop, and a one-entry skid buffer for downstream FIFO backpressure.
- Sits between the router input port and the per-destination FIFOs/synchroniser.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_skid1.sv | 45 ++++
 rtl/router_reg_gen.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and header field helpers for the router input-stage datapath.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    DROP    = 2'd3
  } state_e;

  localparam int unsigned PARITY_XOR = 0;
  localparam int unsigned PARITY_SUM = 1;

  // Header layout: {length, destination}, destination in the low addr_w bits.
  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int unsigned addr_w);
    return hdr & ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int unsigned addr_w);
    return hdr >> addr_w;
  endfunction

endpackage

// File: rtl/router_skid1.sv
// One-entry skid buffer: holds a byte while the downstream FIFO is full.
module router_skid1 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              full_i,
  output logic              valid_o,
  output logic              drain_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Discarded on soft abort, so no drain that cycle.
  assign drain_o = valid_q & ~full_i & ~clr_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i || drain_o) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/router_reg_gen.sv
// Router input-stage packet register: header decode, forwarding with skid,
// checksum/length check and illegal-destination drop.
module router_reg_gen
  import router_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned NUM_PORTS   = 3,
  parameter int unsigned PARITY_MODE = PARITY_XOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  output logic              busy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_wr,
  output logic [ADDR_W-1:0] dest,
  output logic              dest_valid,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              len_err,
  output logic              addr_err
);

  localparam int unsigned     LEN_W   = DATA_W - ADDR_W;
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, par_q, par_d, dout_q, dout_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic              sat_q, sat_d;
  logic              dest_valid_q, dest_valid_d;
  logic              parity_done_q, parity_done_d;
  logic              low_q, low_d;
  logic              err_q, err_d;
  logic              len_err_q, len_err_d;
  logic              addr_err_q, addr_err_d;
  logic              dout_wr_q, dout_wr_d;

  logic              skid_valid, skid_drain;
  logic [DATA_W-1:0] skid_data;
  logic              accept, fwd, push, hdr_legal;
  logic [ADDR_W-1:0] hdr_a;
  logic [LEN_W-1:0]  hdr_l;

  assign hdr_a     = ADDR_W'(hdr_addr(32'(din), ADDR_W));
  assign hdr_l     = LEN_W'(hdr_len(32'(din), ADDR_W));
  assign hdr_legal = (32'(hdr_a) < NUM_PORTS);

  // Every cycle in PAYLOAD/DROP carries a byte; soft abort blocks acceptance.
  always_comb begin
    accept = 1'b0;
    if (!skid_valid && !rst_int_reg) begin
      unique case (state_q)
        IDLE:          accept = pkt_valid;
        PAYLOAD, DROP: accept = 1'b1;
        default:       accept = 1'b0;
      endcase
    end
  end

  assign fwd  = accept && ((state_q == PAYLOAD) || ((state_q == IDLE) && hdr_legal));
  assign push = fwd && fifo_full;

  router_skid1 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rst_int_reg),
    .push_i (push),
    .data_i (din),
    .full_i (fifo_full),
    .valid_o(skid_valid),
    .drain_o(skid_drain),
    .data_o (skid_data)
  );

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    par_d         = par_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    sat_d         = sat_q;
    dest_d        = dest_q;
    dest_valid_d  = dest_valid_q;
    low_d         = low_q;
    err_d         = err_q;
    len_err_d     = len_err_q;
    addr_err_d    = addr_err_q;
    parity_done_d = 1'b0;
    dout_d        = dout_q;
    dout_wr_d     = 1'b0;

    if (rst_int_reg) begin
      state_d      = IDLE;
      dest_valid_d = 1'b0;
      low_d        = 1'b0;
      err_d        = 1'b0;
      len_err_d    = 1'b0;
      addr_err_d   = 1'b0;
    end else begin
      if (skid_drain) begin
        dout_d    = skid_data;
        dout_wr_d = 1'b1;
      end else if (fwd && !fifo_full) begin
        dout_d    = din;
        dout_wr_d = 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            len_d      = hdr_l;
            dest_d     = hdr_a;
            acc_d      = din;
            cnt_d      = '0;
            sat_d      = 1'b0;
            err_d      = 1'b0;
            len_err_d  = 1'b0;
            low_d      = 1'b0;
            addr_err_d = !hdr_legal;
            dest_valid_d = hdr_legal;
            state_d    = hdr_legal ? PAYLOAD : DROP;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            if (pkt_valid) begin
              acc_d = (PARITY_MODE == PARITY_SUM) ? (acc_q + din) : (acc_q ^ din);
              if (cnt_q == CNT_MAX) sat_d = 1'b1;
              else                  cnt_d = cnt_q + LEN_W'(1);
            end else begin
              par_d   = din;
              low_d   = 1'b1;
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          parity_done_d = 1'b1;
          err_d         = (acc_q != par_q);
          len_err_d     = (cnt_q != len_q) || sat_q;
          dest_valid_d  = 1'b0;
          state_d       = IDLE;
        end
        DROP: begin
          if (accept && !pkt_valid) begin
            parity_done_d = 1'b1;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      par_q         <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      sat_q         <= 1'b0;
      dest_q        <= '0;
      dest_valid_q  <= 1'b0;
      parity_done_q <= 1'b0;
      low_q         <= 1'b0;
      err_q         <= 1'b0;
      len_err_q     <= 1'b0;
      addr_err_q    <= 1'b0;
      dout_q        <= '0;
      dout_wr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      par_q         <= par_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      sat_q         <= sat_d;
      dest_q        <= dest_d;
      dest_valid_q  <= dest_valid_d;
      parity_done_q <= parity_done_d;
      low_q         <= low_d;
      err_q         <= err_d;
      len_err_q     <= len_err_d;
      addr_err_q    <= addr_err_d;
      dout_q        <= dout_d;
      dout_wr_q     <= dout_wr_d;
    end
  end

  assign busy          = skid_valid;
  assign dout          = dout_q;
  assign dout_wr       = dout_wr_q;
  assign dest          = dest_q;
  assign dest_valid    = dest_valid_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_q;
  assign err           = err_q;
  assign len_err       = len_err_q;
  assign addr_err      = addr_err_q;

endmodule
